msi_dcache: RTL and testbench

Per-CPU direct-mapped, write-back L1 data cache running the MSI protocol on the cache side of the coherence bus. Sits between one CPU's datapath and the shared memory controller. Toward the controller it is the requester: BusRd, BusRdX and eviction writebacks. Toward the other CPU's requests it is the snoop responder: it supplies dirty data and downgrades or invalidates lines.

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/dcache_frames.sv | 27 ++
 rtl/msi_dcache.sv | 122 ++++++++++++
 tb/tb_msi_dcache.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, MSI frame and cache FSM types for the L1 data cache.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    localparam int TAG_W = 30;
    typedef enum logic [1:0] {I, S, M} msi_t;
    typedef struct packed {
        msi_t             st;
        logic [TAG_W-1:0] tag;
        word_t            data;
    } dcache_frame_t;
    typedef enum logic [1:0] {IDLE, WB, FETCH, SNOOP} dstate_t;
    // Tags are kept zero-extended to TAG_W so the frame layout is independent of SETS.
    function automatic logic [TAG_W-1:0] tag_of(word_t a, int idx_w);
        return TAG_W'(a[31:2] >> idx_w);
    endfunction
endpackage

// File: rtl/dcache_frames.sv
// dcache_frames: direct-mapped frame array with datapath and snoop read ports and one write port.
module dcache_frames
    import cpu_types_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [$clog2(SETS)-1:0]   didx_i,
    input  logic [$clog2(SETS)-1:0]   sidx_i,
    input  logic                      we_i,
    input  logic [$clog2(SETS)-1:0]   widx_i,
    input  dcache_frame_t             wframe_i,
    output dcache_frame_t             dframe_o,
    output dcache_frame_t             sframe_o
);
    dcache_frame_t frames_q [SETS];
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < SETS; k++) frames_q[k] <= '0;
        end else if (we_i) begin
            frames_q[widx_i] <= wframe_i;
        end
    end
    assign dframe_o = frames_q[didx_i];
    assign sframe_o = frames_q[sidx_i];
endmodule

// File: rtl/msi_dcache.sv
// msi_dcache: direct-mapped write-back L1 data cache, MSI requester and snoop responder.
module msi_dcache
    import cpu_types_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    output logic        cctrans,
    output logic        ccwrite,
    input  logic        dwait,
    input  logic [31:0] dload,
    input  logic        ccwait,
    input  logic [31:0] ccsnoopaddr,
    input  logic        ccinv
);
    localparam int IDX = $clog2(SETS);
    dstate_t          state_q, state_d;
    dcache_frame_t    dframe, sframe, wframe;
    logic             we, dmatch, smatch;
    logic [IDX-1:0]   didx, sidx, widx;
    logic [TAG_W-1:0] dtag, stag;
    assign didx   = dmemaddr[IDX+1:2];
    assign sidx   = ccsnoopaddr[IDX+1:2];
    assign dtag   = tag_of(dmemaddr, IDX);
    assign stag   = tag_of(ccsnoopaddr, IDX);
    assign dmatch = dframe.st != I && dframe.tag == dtag;
    assign smatch = sframe.st != I && sframe.tag == stag;
    dcache_frames #(.SETS(SETS)) u_frames (
        .clk_i(CLK), .rst_ni(nRST), .didx_i(didx), .sidx_i(sidx),
        .we_i(we), .widx_i(widx), .wframe_i(wframe),
        .dframe_o(dframe), .sframe_o(sframe)
    );
    always_comb begin
        state_d  = state_q;
        we       = 1'b0;
        widx     = didx;
        wframe   = dframe;
        dhit     = 1'b0;
        dmemload = '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        cctrans  = 1'b0;
        ccwrite  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ccwait) state_d = SNOOP;
                else if (dmemREN && dmatch) begin
                    dhit     = 1'b1;
                    dmemload = dframe.data;
                end else if (dmemWEN && dmatch && dframe.st == M) begin
                    dhit        = 1'b1;
                    we          = 1'b1;
                    wframe.data = dmemstore;
                end else if (dmemREN || dmemWEN) state_d = (!dmatch && dframe.st == M) ? WB : FETCH;
            end
            // A snoop preempts our own bus request before the controller has accepted it.
            WB: begin
                if (ccwait) state_d = SNOOP;
                else begin
                    dWEN   = 1'b1;
                    daddr  = word_t'({dframe.tag, didx, 2'b00});
                    dstore = dframe.data;
                    if (!dwait) begin
                        we        = 1'b1;
                        wframe.st = I;
                        state_d   = FETCH;
                    end
                end
            end
            FETCH: begin
                if (ccwait) state_d = SNOOP;
                else begin
                    dREN    = 1'b1;
                    cctrans = 1'b1;
                    ccwrite = dmemWEN;
                    daddr   = dmemaddr;
                    if (!dwait) begin
                        we          = 1'b1;
                        wframe.st   = dmemWEN ? M : S;
                        wframe.tag  = dtag;
                        wframe.data = dload;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                widx   = sidx;
                wframe = sframe;
                if (smatch && sframe.st == M) begin
                    dWEN   = 1'b1;
                    daddr  = ccsnoopaddr;
                    dstore = sframe.data;
                    if (!dwait) begin
                        we        = 1'b1;
                        wframe.st = ccinv ? I : S;
                    end
                end else if (smatch && ccinv) begin
                    we        = 1'b1;
                    wframe.st = I;
                end
                if (!ccwait) state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else state_q <= state_d;
    end
endmodule

// File: tb/tb_msi_dcache.sv
// tb_msi_dcache: directed MSI cache scenarios checked against an architectural memory model.
module tb_msi_dcache;
    logic        CLK = 1'b0, nRST = 1'b0;
    logic        dmemREN = 1'b0, dmemWEN = 1'b0;
    logic [31:0] dmemaddr = '0, dmemstore = '0;
    logic        dhit, dREN, dWEN, cctrans, ccwrite;
    logic [31:0] dmemload, daddr, dstore;
    logic        dwait = 1'b1, ccwait = 1'b0, ccinv = 1'b0;
    logic [31:0] dload = '0, ccsnoopaddr = '0;
    int          n_cmp = 0, n_err = 0;
    logic [31:0] bmem   [logic [31:0]];
    logic [31:0] golden [logic [31:0]];
    int          lat = 2, cnt = 0;
    int          n_rd = 0, n_wr = 0;
    logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0;
    logic        rd_ccw = 1'b0, cw_prev = 1'b0;

    always #5 CLK = ~CLK;

    msi_dcache dut (
        .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait), .dload(dload),
        .ccwait(ccwait), .ccsnoopaddr(ccsnoopaddr), .ccinv(ccinv)
    );

    function automatic logic [31:0] initv(logic [31:0] a);
        return 32'h1000_0000 ^ a;
    endfunction
    function automatic logic [31:0] bval(logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : initv(a);
    endfunction
    // Architectural value: the last store the CPU completed, else the initial memory image.
    function automatic logic [31:0] gval(logic [31:0] a);
        return golden.exists(a) ? golden[a] : initv(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Controller: completes any bus access after lat wait cycles.
    always @(negedge CLK) begin
        if (dREN || dWEN) begin
            dload = bval(daddr);
            dwait = (cnt != lat);
            cnt   = (cnt == lat) ? 0 : cnt + 1;
        end else begin
            dwait = 1'b1;
            cnt   = 0;
        end
    end

    always @(posedge CLK) begin
        if (nRST) begin
            if (dWEN && !dwait) begin
                bmem[daddr] = dstore;
                n_wr++;
                wr_addr = daddr;
                wr_data = dstore;
            end
            if (dREN && !dwait) begin
                n_rd++;
                rd_addr = daddr;
                rd_ccw  = ccwrite;
            end
            if (dhit && dmemWEN) golden[dmemaddr] = dmemstore;
        end
        cw_prev = nRST && ccwait;
    end

    always @(negedge CLK) begin
        if (nRST) begin
            if (dhit && dmemREN) check("load_data", dmemload, gval(dmemaddr));
            if (dWEN) begin
                check("wb_data", dstore, gval(daddr));
                check("wb_excl", 32'({dREN, cctrans}), 32'd0);
            end
            if (dREN) begin
                check("rd_addr", daddr, dmemaddr);
                check("rd_ctl", 32'({cctrans, ccwrite}), 32'({1'b1, dmemWEN}));
            end
            if (cw_prev) check("snoop_no_rd", 32'(dREN), 32'd0);
            if (!cw_prev && !dmemREN && !dmemWEN) check("quiet", 32'({dhit, dREN, dWEN}), 32'd0);
        end
    end

    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output int cyc, output logic [31:0] ld);
        dmemREN = !wr; dmemWEN = wr; dmemaddr = a; dmemstore = d; cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!dhit && cyc < 200);
        if (!dhit) begin
            n_cmp++; n_err++;
            $display("FAIL access_timeout: addr %h got no dhit within %0d cycles", a, cyc);
        end
        ld = dmemload;
        @(posedge CLK); #1;
        dmemREN = 1'b0; dmemWEN = 1'b0;
    endtask

    task automatic snoop(input logic [31:0] a, input logic inv, output logic wen_t,
                         output logic wen_t1, output logic [31:0] st_t1, output logic [31:0] ad_t1,
                         output logic wen_t4);
        ccwait = 1'b1; ccsnoopaddr = a; ccinv = 1'b0;
        @(negedge CLK); wen_t = dWEN;
        @(posedge CLK); #1; ccinv = inv;
        @(negedge CLK); wen_t1 = dWEN; st_t1 = dstore; ad_t1 = daddr;
        repeat (3) @(negedge CLK);
        wen_t4 = dWEN;
        @(posedge CLK); #1; ccwait = 1'b0; ccinv = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, r0, w0;
        logic [31:0] ld, st1, ad1;
        logic w_t, w_t1, w_t4;
        bmem[32'h40] = 32'hDEAD_BEEF;
        golden[32'h40] = 32'hDEAD_BEEF;
        @(negedge CLK);
        check("reset_ctl", 32'({dhit, dREN, dWEN, cctrans, ccwrite}), 32'd0);
        check("reset_daddr", daddr, 32'd0);
        check("reset_dstore", dstore, 32'd0);
        check("reset_load", dmemload, 32'd0);
        nRST = 1'b1;
        @(posedge CLK); #1;
        // cold load: IDLE miss, three FETCH cycles, IDLE hit
        r0 = n_rd; w0 = n_wr;
        access(1'b0, 32'h40, 32'h0, cyc, ld);
        check("t1_cycles", 32'(cyc), 32'd5);
        check("t1_data", ld, 32'hDEAD_BEEF);
        check("t1_rd", 32'(n_rd - r0), 32'd1);
        check("t1_ccw", 32'(rd_ccw), 32'd0);
        check("t1_nowr", 32'(n_wr - w0), 32'd0);
        access(1'b0, 32'h40, 32'h0, cyc, ld);
        check("t1_rehit", 32'(cyc), 32'd1);
        // store on S upgrades through BusRdX
        r0 = n_rd;
        access(1'b1, 32'h40, 32'd5, cyc, ld);
        check("t2_cycles", 32'(cyc), 32'd5);
        check("t2_rd", 32'(n_rd - r0), 32'd1);
        check("t2_ccw", 32'(rd_ccw), 32'd1);
        access(1'b0, 32'h40, 32'h0, cyc, ld);
        check("t2_load", ld, 32'd5);
        r0 = n_rd;
        access(1'b1, 32'h40, 32'd6, cyc, ld);
        check("t2_mhit", 32'(cyc), 32'd1);
        check("t2_mhit_nobus", 32'(n_rd - r0), 32'd0);
        // dirty victim: WB then FETCH
        r0 = n_rd; w0 = n_wr;
        access(1'b0, 32'h80, 32'h0, cyc, ld);
        check("t3_cycles", 32'(cyc), 32'd8);
        check("t3_wr", 32'(n_wr - w0), 32'd1);
        check("t3_wr_addr", wr_addr, 32'h40);
        check("t3_wr_data", wr_data, 32'd6);
        check("t3_mem", bval(32'h40), 32'd6);
        check("t3_rd_addr", rd_addr, 32'h80);
        check("t3_data", ld, 32'h1000_0080);
        // snoop hit on M, no invalidate
        access(1'b1, 32'h80, 32'd7, cyc, ld);
        check("t4_upgrade", 32'(cyc), 32'd5);
        w0 = n_wr;
        snoop(32'h80, 1'b0, w_t, w_t1, st1, ad1, w_t4);
        check("t4_dwen_t", 32'(w_t), 32'd0);
        check("t4_dwen_t1", 32'(w_t1), 32'd1);
        check("t4_dstore", st1, 32'd7);
        check("t4_daddr", ad1, 32'h80);
        check("t4_dwen_done", 32'(w_t4), 32'd0);
        check("t4_wr", 32'(n_wr - w0), 32'd1);
        check("t4_mem", bval(32'h80), 32'd7);
        access(1'b0, 32'h80, 32'h0, cyc, ld);
        check("t4_shit", 32'(cyc), 32'd1);
        check("t4_sdata", ld, 32'd7);
        access(1'b1, 32'h80, 32'd8, cyc, ld);
        check("t4_is_s", 32'(cyc), 32'd5);
        // downgrade to S, then invalidate the S line
        snoop(32'h80, 1'b0, w_t, w_t1, st1, ad1, w_t4);
        check("t5_wb8", st1, 32'd8);
        w0 = n_wr;
        snoop(32'h80, 1'b1, w_t, w_t1, st1, ad1, w_t4);
        check("t5_dwen_t1", 32'(w_t1), 32'd0);
        check("t5_nowr", 32'(n_wr - w0), 32'd0);
        access(1'b0, 32'h80, 32'h0, cyc, ld);
        check("t5_miss", 32'(cyc), 32'd5);
        check("t5_data", ld, 32'd8);
        // snoop preempts a pending FETCH, which is reissued afterwards
        lat = 6; r0 = n_rd;
        dmemREN = 1'b1; dmemaddr = 32'hC0;
        @(negedge CLK);
        @(negedge CLK);
        check("t6_fetch", 32'(dREN), 32'd1);
        @(posedge CLK); #1; ccwait = 1'b1; ccsnoopaddr = 32'h100;
        @(negedge CLK);
        check("t6_drop", 32'(dREN), 32'd0);
        @(negedge CLK);
        check("t6_snoop_dwen", 32'(dWEN), 32'd0);
        @(posedge CLK); #1; ccwait = 1'b0;
        cyc = 4;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!dhit && cyc < 200);
        check("t6_cycles", 32'(cyc), 32'd14);
        check("t6_data", dmemload, 32'h1000_00C0);
        check("t6_rd", 32'(n_rd - r0), 32'd1);
        @(posedge CLK); #1; dmemREN = 1'b0;
        // asynchronous reset mid-FETCH
        lat = 2;
        dmemREN = 1'b1; dmemaddr = 32'h40;
        @(negedge CLK);
        @(negedge CLK);
        check("t7_fetch", 32'(dREN), 32'd1);
        #2; nRST = 1'b0; #1;
        check("t7_async_ctl", 32'({dhit, dREN, dWEN, cctrans, ccwrite}), 32'd0);
        check("t7_async_daddr", daddr, 32'd0);
        dmemREN = 1'b0;
        @(negedge CLK); nRST = 1'b1;
        @(posedge CLK); #1;
        access(1'b0, 32'hC0, 32'h0, cyc, ld);
        check("t7_inval", 32'(cyc), 32'd5);
        check("t7_data", ld, 32'h1000_00C0);
        access(1'b0, 32'h40, 32'h0, cyc, ld);
        check("t7_evict_s", 32'(cyc), 32'd5);
        check("t7_data40", ld, 32'd6);
        repeat (2) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
